// File: rtl/axis2adi_pkg.sv
// Shared types and bit positions for the AXI-Stream to DAC-FIFO bridge.
package axis2adi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int CTRL_ENABLE    = 0;
   localparam int CTRL_WAIT_TRIG = 1;
   localparam int CTRL_CLR_STAT  = 2;

   localparam int STAT_BUSY        = 0;
   localparam int STAT_DONE        = 1;
   localparam int STAT_UNF         = 2;
   localparam int STAT_EARLY_TLAST = 3;
   localparam int STAT_LATE_TLAST  = 4;

endpackage

// File: rtl/axis2adi_fifo.sv
// Synchronous FIFO of 2**AW words; full/empty come from pointers carrying an extra wrap bit.
module axis2adi_fifo #(
   parameter int W  = 64,
   parameter int AW = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o,
   output logic         one_o
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [2**AW];

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign one_o   = ((wr_ptr_q - rd_ptr_q) == PTR_ONE);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_i && !full_o)  wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_i  && !empty_o) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: a word is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/axis2adi_conv.sv
// AXI-Stream slave feeding an ADI DAC FIFO: buffers a bounded transfer and hands words
// to the DAC core on its read strobe, with trigger gating, abort and sticky error flags.
module axis2adi_conv
   import axis2adi_pkg::*;
#(
   parameter int C_S_AXIS_TDATA_NUM_BYTES = 8,
   parameter int C_FIFO_DEPTH_LOG2        = 4
) (
   input  logic                                  AXIS_ACLK,
   input  logic                                  AXIS_ARESETN,
   input  logic                                  S_AXIS_TVALID,
   input  logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0] S_AXIS_TDATA,
   input  logic [C_S_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TSTRB,
   input  logic                                  S_AXIS_TLAST,
   output logic                                  S_AXIS_TREADY,
   output logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0] ddata,
   input  logic                                  dvalid,
   output logic                                  dunf,
   input  logic [31:0]                           ctrl,
   output logic [31:0]                           stat,
   input  logic [31:0]                           num_bytes,
   input  logic                                  trig,
   output state_t                                dbg_state_o
);

   localparam int unsigned NB = C_S_AXIS_TDATA_NUM_BYTES;
   localparam int          W  = 8 * C_S_AXIS_TDATA_NUM_BYTES;

   state_t       state_q, state_d;
   logic         en_q;
   logic [31:0]  len_q, len_d, cnt_q, cnt_d, cnt_next;
   logic [32:0]  len_round;
   logic [W-1:0] ddata_q, ddata_d;
   logic         dunf_q;
   logic [2:0]   sticky_q, sticky_d;

   logic         enable, wait_trig, clr_stat;
   logic         beat_acc, final_beat, dac_active, pop, underflow, abort;
   logic         fifo_full, fifo_empty, fifo_one;
   logic [W-1:0] fifo_head;
   logic         unused_ok;

   assign enable    = ctrl[CTRL_ENABLE];
   assign wait_trig = ctrl[CTRL_WAIT_TRIG];
   assign clr_stat  = ctrl[CTRL_CLR_STAT];
   assign unused_ok = ^{S_AXIS_TSTRB, ctrl[31:3]};

   // Round the byte count up to whole beats; 33 bits keeps the add from overflowing.
   assign len_round = (({1'b0, num_bytes} + 33'(NB - 1)) / 33'(NB)) * 33'(NB);

   assign S_AXIS_TREADY = (state_q == ST_RUN) && !fifo_full;
   assign beat_acc      = S_AXIS_TVALID && S_AXIS_TREADY;
   assign cnt_next      = cnt_q + 32'(NB);
   assign final_beat    = (cnt_next >= len_q);
   assign dac_active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign pop           = dac_active && dvalid && !fifo_empty;
   assign underflow     = dac_active && dvalid && fifo_empty;
   assign abort         = !enable && ((state_q == ST_ARM) || (state_q == ST_RUN) || (state_q == ST_DRAIN));

   axis2adi_fifo #(
      .W  (W),
      .AW (C_FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk_i   (AXIS_ACLK),
      .rst_ni  (AXIS_ARESETN),
      .flush_i (abort),
      .push_i  (beat_acc),
      .wdata_i (S_AXIS_TDATA),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .one_o   (fifo_one)
   );

   // RUN leaves on the accepting edge of the final beat, so TREADY never offers an extra beat.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      if (beat_acc) cnt_d = cnt_next;
      case (state_q)
         ST_IDLE: if (enable && !en_q) begin
            state_d = ST_ARM;
            len_d   = 32'(len_round);
            cnt_d   = '0;
         end
         ST_ARM: begin
            if (!enable)                    state_d = ST_IDLE;
            else if (len_q == '0)           state_d = ST_DONE;
            else if (!wait_trig || trig)    state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable)                    state_d = ST_IDLE;
            else if (beat_acc && final_beat) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!enable)                          state_d = ST_IDLE;
            else if (fifo_empty || (pop && fifo_one)) state_d = ST_DONE;
         end
         ST_DONE: if (!enable) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ddata_d = ddata_q;
      if (!dac_active)    ddata_d = '0;
      else if (pop)       ddata_d = fifo_head;
      else if (underflow) ddata_d = '0;
   end

   // A new event wins over a clear arriving in the same cycle.
   assign sticky_d = (sticky_q & {3{!clr_stat}})
                   | {beat_acc && !S_AXIS_TLAST && final_beat,
                      beat_acc &&  S_AXIS_TLAST && !final_beat,
                      underflow};

   always_ff @(posedge AXIS_ACLK) begin
      if (!AXIS_ARESETN) begin
         state_q  <= ST_IDLE;
         en_q     <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         ddata_q  <= '0;
         dunf_q   <= 1'b0;
         sticky_q <= '0;
      end else begin
         state_q  <= state_d;
         en_q     <= enable;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         ddata_q  <= ddata_d;
         dunf_q   <= underflow;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      stat                                  = '0;
      stat[STAT_BUSY]                       = (state_q == ST_ARM) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
      stat[STAT_DONE]                       = (state_q == ST_DONE);
      stat[STAT_LATE_TLAST:STAT_UNF]        = sticky_q;
   end

   assign ddata       = ddata_q;
   assign dunf        = dunf_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axis2adi_conv.sv
// Bench for axis2adi_conv: randomized stream traffic against a transfer-level model that
// tracks buffered words, byte count, phase and sticky flags once per clock.
module tb_axis2adi_conv;
   import axis2adi_pkg::*;

   localparam int NB    = 8;
   localparam int W     = 64;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int MP_IDLE = 0, MP_ARM = 1, MP_RUN = 2, MP_DRAIN = 3, MP_DONE = 4;

   logic          clk = 1'b0;
   logic          arstn;
   logic          tvalid, tlast, tready, dvalid, dunf, trig;
   logic [W-1:0]  tdata, ddata;
   logic [NB-1:0] tstrb;
   logic [31:0]   ctrl, stat, num_bytes;
   state_t        dbg_state;

   always #5 clk = ~clk;

   axis2adi_conv #(
      .C_S_AXIS_TDATA_NUM_BYTES (NB),
      .C_FIFO_DEPTH_LOG2        (AW)
   ) dut (
      .AXIS_ACLK     (clk),
      .AXIS_ARESETN  (arstn),
      .S_AXIS_TVALID (tvalid),
      .S_AXIS_TDATA  (tdata),
      .S_AXIS_TSTRB  (tstrb),
      .S_AXIS_TLAST  (tlast),
      .S_AXIS_TREADY (tready),
      .ddata         (ddata),
      .dvalid        (dvalid),
      .dunf          (dunf),
      .ctrl          (ctrl),
      .stat          (stat),
      .num_bytes     (num_bytes),
      .trig          (trig),
      .dbg_state_o   (dbg_state)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: exp_q holds words accepted but not yet handed to the DAC.
   logic [W-1:0] exp_q[$];
   int           m_phase;
   longint       m_len, m_cnt;
   logic         m_en_prev, m_unf;
   logic [W-1:0] m_dd;
   logic [2:0]   m_st;

   int   c_rdy_bad, c_dd_bad, c_unf_bad, c_stat_bad;
   int   acc_cnt, pop_cnt, unf_cnt, m_under_cnt, rdy_hi_cnt;
   logic last_acc;
   int   s_idx;
   logic [W-1:0] s_data;

   function automatic logic [31:0] exp_stat();
      logic [31:0] s;
      s    = '0;
      s[0] = (m_phase == MP_ARM) || (m_phase == MP_RUN) || (m_phase == MP_DRAIN);
      s[1] = (m_phase == MP_DONE);
      s[4:2] = m_st;
      return s;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_phase = MP_IDLE; m_len = 0; m_cnt = 0;
      m_en_prev = 1'b0; m_unf = 1'b0; m_dd = '0; m_st = '0;
   endtask

   task automatic clear_counts();
      c_rdy_bad = 0; c_dd_bad = 0; c_unf_bad = 0; c_stat_bad = 0;
      acc_cnt = 0; pop_cnt = 0; unf_cnt = 0; m_under_cnt = 0; rdy_hi_cnt = 0;
   endtask

   task automatic new_data();
      s_data = {$urandom, $urandom};
   endtask

   // Called at a falling edge: drive, advance the model across the next rising edge,
   // then record where the DUT outputs disagree with the model.
   task automatic tick(input logic tv, input logic tl, input logic dv);
      logic en, acc, dac_on, pop, under, early, late;
      tvalid = tv; tdata = s_data; tlast = tl; dvalid = dv; tstrb = '1;
      acc = 1'b0;
      if (!arstn) begin
         model_reset();
      end else begin
         en  = ctrl[0];
         acc = tv && (tready === 1'b1);
         if (tready === 1'b1) rdy_hi_cnt++;
         dac_on = (m_phase == MP_RUN) || (m_phase == MP_DRAIN);
         pop    = dac_on && dv && (exp_q.size() > 0);
         under  = dac_on && dv && (exp_q.size() == 0);
         if (!dac_on)    m_dd = '0;
         else if (pop)   m_dd = exp_q[0];
         else if (under) m_dd = '0;
         if (pop) begin
            void'(exp_q.pop_front());
            pop_cnt++;
         end
         if (under) m_under_cnt++;
         early = 1'b0; late = 1'b0;
         if (acc) begin
            early = tl && (m_cnt + NB < m_len);
            late  = !tl && (m_cnt + NB >= m_len);
            m_cnt += NB;
            exp_q.push_back(s_data);
            acc_cnt++;
         end
         m_unf = under;
         if (ctrl[2]) m_st = '0;
         m_st = m_st | {late, early, under};
         case (m_phase)
            MP_IDLE: if (en && !m_en_prev) begin
               m_phase = MP_ARM;
               m_len   = ((longint'(num_bytes) + NB - 1) / NB) * NB;
               m_cnt   = 0;
            end
            MP_ARM: begin
               if (!en) begin m_phase = MP_IDLE; exp_q.delete(); end
               else if (m_len == 0) m_phase = MP_DONE;
               else if (!ctrl[1] || trig) m_phase = MP_RUN;
            end
            MP_RUN: begin
               if (!en) begin m_phase = MP_IDLE; exp_q.delete(); end
               else if (acc && m_cnt >= m_len) m_phase = MP_DRAIN;
            end
            MP_DRAIN: begin
               if (!en) begin m_phase = MP_IDLE; exp_q.delete(); end
               else if (exp_q.size() == 0) m_phase = MP_DONE;
            end
            default: if (!en) m_phase = MP_IDLE;
         endcase
         m_en_prev = en;
      end
      last_acc = acc;
      @(posedge clk);
      @(negedge clk);
      if (tready !== ((m_phase == MP_RUN) && (exp_q.size() < DEPTH))) c_rdy_bad++;
      if (ddata !== m_dd)      c_dd_bad++;
      if (dunf !== m_unf)      c_unf_bad++;
      if (dunf === 1'b1)       unf_cnt++;
      if (stat !== exp_stat()) c_stat_bad++;
   endtask

   // Offers beats s_idx..nbeats-1; dvalid runs once dv_from beats have been accepted.
   task automatic run_stream(input int nbeats, input int last_at, input int dv_from,
                             input int tv_pct, input int budget);
      logic tv;
      for (int cyc = 0; cyc < budget && m_phase != MP_DONE; cyc++) begin
         tv = (s_idx < nbeats) && ($urandom_range(99) < tv_pct);
         tick(tv, (s_idx + 1 == last_at), (acc_cnt >= dv_from));
         if (last_acc) begin
            s_idx++;
            new_data();
         end
      end
   endtask

   task automatic go_idle();
      ctrl = '0; trig = 1'b0;
      repeat (2) tick(1'b0, 1'b0, 1'b0);
      clear_counts();
      s_idx = 0;
      new_data();
   endtask

   task automatic test_reset();
      arstn = 1'b0; ctrl = '0; trig = 1'b0; num_bytes = '0; s_data = '0;
      clear_counts();
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      arstn = 1'b1;
      total++; if (ddata !== '0) begin bad++; $display("FAIL reset_ddata: got %0h want 0", ddata); end
      total++; if (tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", tready); end
      total++; if (dunf !== 1'b0) begin bad++; $display("FAIL reset_dunf: got %b want 0", dunf); end
      total++; if (stat !== 32'd0) begin bad++; $display("FAIL reset_stat: got %0h want 0", stat); end
      total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_basic();
      go_idle();
      num_bytes = 32'd64; ctrl = 32'h1;
      run_stream(8, 8, 3, 100, 200);
      total++; if (acc_cnt !== 8) begin bad++; $display("FAIL basic_beats: got %0d want 8", acc_cnt); end
      total++; if (pop_cnt !== 8) begin bad++; $display("FAIL basic_delivered: got %0d want 8", pop_cnt); end
      total++; if (stat[1] !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", stat[1]); end
      total++; if (stat[4:2] !== 3'b000) begin bad++; $display("FAIL basic_sticky: got %b want 000", stat[4:2]); end
      total++; if (c_dd_bad !== 0) begin bad++; $display("FAIL basic_ddata: %0d cycles off model, want 0", c_dd_bad); end
      total++; if (c_rdy_bad + c_unf_bad + c_stat_bad !== 0) begin bad++; $display("FAIL basic_model: rdy=%0d unf=%0d stat=%0d want 0", c_rdy_bad, c_unf_bad, c_stat_bad); end
   endtask

   task automatic test_trigger();
      go_idle();
      num_bytes = 32'd32; ctrl = 32'h3;
      repeat (100) tick(1'b1, 1'b0, 1'b0);
      total++; if (rdy_hi_cnt !== 0) begin bad++; $display("FAIL trig_wait_tready: high %0d cycles, want 0", rdy_hi_cnt); end
      total++; if (acc_cnt !== 0) begin bad++; $display("FAIL trig_wait_beats: got %0d want 0", acc_cnt); end
      trig = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      trig = 1'b0;
      total++; if (tready !== 1'b1) begin bad++; $display("FAIL trig_run_tready: got %b want 1", tready); end
      run_stream(4, 4, 1, 100, 100);
      total++; if (acc_cnt !== 4) begin bad++; $display("FAIL trig_beats: got %0d want 4", acc_cnt); end
      total++; if (stat[1] !== 1'b1) begin bad++; $display("FAIL trig_done: got %b want 1", stat[1]); end
      total++; if (c_rdy_bad + c_dd_bad + c_unf_bad + c_stat_bad !== 0) begin bad++; $display("FAIL trig_model: rdy=%0d dd=%0d unf=%0d stat=%0d want 0", c_rdy_bad, c_dd_bad, c_unf_bad, c_stat_bad); end
   endtask

   task automatic test_underflow();
      go_idle();
      num_bytes = 32'd128; ctrl = 32'h1;
      run_stream(16, 16, 0, 40, 600);
      total++; if (unf_cnt !== m_under_cnt) begin bad++; $display("FAIL unf_pulses: got %0d want %0d", unf_cnt, m_under_cnt); end
      total++; if (stat[2] !== 1'b1) begin bad++; $display("FAIL unf_sticky: got %b want 1", stat[2]); end
      total++; if (c_dd_bad + c_unf_bad !== 0) begin bad++; $display("FAIL unf_ddata: dd=%0d unf=%0d cycles off, want 0", c_dd_bad, c_unf_bad); end
      total++; if (stat[1] !== 1'b1) begin bad++; $display("FAIL unf_done: got %b want 1", stat[1]); end
      ctrl = 32'h5;
      tick(1'b0, 1'b0, 1'b0);
      ctrl = 32'h1;
      tick(1'b0, 1'b0, 1'b0);
      total++; if (stat[2] !== 1'b0) begin bad++; $display("FAIL unf_clear: got %b want 0", stat[2]); end
      total++; if (c_rdy_bad + c_stat_bad !== 0) begin bad++; $display("FAIL unf_model: rdy=%0d stat=%0d want 0", c_rdy_bad, c_stat_bad); end
   endtask

   task automatic test_backpressure();
      go_idle();
      num_bytes = 32'd320; ctrl = 32'h1;
      run_stream(40, 40, 1000, 100, 40);
      total++; if (acc_cnt !== DEPTH) begin bad++; $display("FAIL bp_fill: got %0d want %0d", acc_cnt, DEPTH); end
      total++; if (tready !== 1'b0) begin bad++; $display("FAIL bp_tready: got %b want 0", tready); end
      run_stream(40, 40, 0, 100, 400);
      total++; if (pop_cnt !== 40) begin bad++; $display("FAIL bp_delivered: got %0d want 40", pop_cnt); end
      total++; if (stat[1] !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1", stat[1]); end
      total++; if (stat[4:2] !== 3'b000) begin bad++; $display("FAIL bp_sticky: got %b want 000", stat[4:2]); end
      total++; if (c_rdy_bad + c_dd_bad + c_unf_bad + c_stat_bad !== 0) begin bad++; $display("FAIL bp_model: rdy=%0d dd=%0d unf=%0d stat=%0d want 0", c_rdy_bad, c_dd_bad, c_unf_bad, c_stat_bad); end
   endtask

   task automatic test_short_and_zero();
      go_idle();
      num_bytes = 32'd20; ctrl = 32'h1;
      run_stream(3, 2, 1, 100, 100);
      total++; if (acc_cnt !== 3) begin bad++; $display("FAIL short_beats: got %0d want 3", acc_cnt); end
      total++; if (stat[3] !== 1'b1) begin bad++; $display("FAIL short_early: got %b want 1", stat[3]); end
      total++; if (stat[4] !== 1'b1) begin bad++; $display("FAIL short_late: got %b want 1", stat[4]); end
      total++; if (c_rdy_bad + c_dd_bad + c_unf_bad + c_stat_bad !== 0) begin bad++; $display("FAIL short_model: rdy=%0d dd=%0d unf=%0d stat=%0d want 0", c_rdy_bad, c_dd_bad, c_unf_bad, c_stat_bad); end
      ctrl = 32'h4;
      tick(1'b0, 1'b0, 1'b0);
      go_idle();
      num_bytes = 32'd0; ctrl = 32'h1;
      repeat (6) tick(1'b1, 1'b0, 1'b1);
      total++; if (stat[1:0] !== 2'b10) begin bad++; $display("FAIL zero_done: got %b want 10", stat[1:0]); end
      total++; if (rdy_hi_cnt !== 0) begin bad++; $display("FAIL zero_tready: high %0d cycles, want 0", rdy_hi_cnt); end
      total++; if (c_stat_bad + c_dd_bad !== 0) begin bad++; $display("FAIL zero_model: stat=%0d dd=%0d want 0", c_stat_bad, c_dd_bad); end
   endtask

   task automatic test_abort();
      go_idle();
      num_bytes = 32'd128; ctrl = 32'h1;
      for (int cyc = 0; cyc < 50 && acc_cnt < 3; cyc++) begin
         tick(1'b1, 1'b0, 1'b0);
         if (last_acc) new_data();
      end
      ctrl = 32'h0;
      repeat (2) tick(1'b0, 1'b0, 1'b0);
      total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL abort_state: got %0d want %0d", dbg_state, ST_IDLE); end
      total++; if (stat[1:0] !== 2'b00) begin bad++; $display("FAIL abort_stat: got %b want 00", stat[1:0]); end
      clear_counts();
      s_idx = 0;
      num_bytes = 32'd16; ctrl = 32'h1;
      run_stream(2, 2, 0, 100, 100);
      total++; if (acc_cnt !== 2) begin bad++; $display("FAIL abort_restart_beats: got %0d want 2", acc_cnt); end
      total++; if (pop_cnt !== 2) begin bad++; $display("FAIL abort_restart_delivered: got %0d want 2", pop_cnt); end
      total++; if (stat[1] !== 1'b1) begin bad++; $display("FAIL abort_restart_done: got %b want 1", stat[1]); end
      total++; if (c_rdy_bad + c_dd_bad + c_unf_bad + c_stat_bad !== 0) begin bad++; $display("FAIL abort_model: rdy=%0d dd=%0d unf=%0d stat=%0d want 0", c_rdy_bad, c_dd_bad, c_unf_bad, c_stat_bad); end
   endtask

   initial begin
      tvalid = 1'b0; tdata = '0; tlast = 1'b0; tstrb = '1; dvalid = 1'b0;
      arstn = 1'b0; ctrl = '0; trig = 1'b0; num_bytes = '0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_basic();
      test_trigger();
      test_underflow();
      test_backpressure();
      test_short_and_zero();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
